// File: rtl/uart_tx_arbiter.sv
// Arbitrates one UART transmitter among N_REQ printers with rotating priority,
// whole-dump ownership and a watchdog that reclaims the UART from stalled owners.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ-1:0]   i_cli_tx_start,
    input  logic [8*N_REQ-1:0] i_cli_tx_data,
    input  logic [N_REQ-1:0]   i_cli_done,
    input  logic               i_uart_busy,
    output logic               o_uart_start,
    output logic [7:0]         o_uart_data,
    output logic [N_REQ-1:0]   o_cli_busy,
    output logic [N_REQ-1:0]   o_grant,
    output logic [2:0]         o_active_id,
    output logic               o_timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRelease
    } state_e;

    localparam logic [19:0] WdogLast = TIMEOUT_CYC - 20'd1;

    state_e           r_state;
    logic [N_REQ-1:0] r_grant;
    logic [2:0]       r_active_id;
    logic [2:0]       r_rr_ptr;
    logic [19:0]      r_wdog;
    logic             r_timeout_err;

    state_e           w_state_next;
    logic [N_REQ-1:0] w_grant_next;
    logic [2:0]       w_active_next;
    logic [2:0]       w_rr_next;
    logic [19:0]      w_wdog_next;
    logic             w_timeout_next;

    // Padded to 8 lanes so a 3-bit index always fits, whatever N_REQ is.
    logic [7:0]       w_req_pad;
    logic [7:0]       w_done_pad;
    logic [63:0]      w_data_pad;
    logic [7:0]       w_onehot;
    logic [3:0]       w_idx;
    logic [3:0]       w_rr_inc;
    logic [2:0]       w_pick_id;
    logic             w_pick_found;
    logic             w_uart_start;

    assign w_req_pad  = 8'(i_req);
    assign w_done_pad = 8'(i_cli_done);
    assign w_data_pad = 64'(i_cli_tx_data);

    // Rotating scan starting at r_rr_ptr; wrap by compare so any N_REQ works.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = 3'd0;
        w_idx        = 4'd0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_rr_ptr} + 4'(i);
            if (w_idx >= 4'(N_REQ)) begin
                w_idx = w_idx - 4'(N_REQ);
            end
            if (!w_pick_found && w_req_pad[w_idx[2:0]]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_idx[2:0];
            end
        end
    end

    assign w_onehot = 8'd1 << w_pick_id;
    assign w_rr_inc = {1'b0, r_active_id} + 4'd1;

    always_comb begin
        w_state_next   = r_state;
        w_grant_next   = r_grant;
        w_active_next  = r_active_id;
        w_rr_next      = r_rr_ptr;
        w_wdog_next    = r_wdog;
        w_timeout_next = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_pick_found) begin
                    w_grant_next  = w_onehot[N_REQ-1:0];
                    w_active_next = w_pick_id;
                    w_wdog_next   = 20'd0;
                    w_state_next  = StHold;
                end
            end
            StHold: begin
                if (w_uart_start || i_uart_busy) begin
                    w_wdog_next = 20'd0;
                end else begin
                    w_wdog_next = r_wdog + 20'd1;
                end
                // A done in the timeout cycle wins: normal release, no error.
                if (w_done_pad[r_active_id]) begin
                    w_state_next = StRelease;
                end else if (r_wdog == WdogLast) begin
                    w_state_next   = StRelease;
                    w_timeout_next = 1'b1;
                end
            end
            StRelease: begin
                w_grant_next = '0;
                w_wdog_next  = 20'd0;
                w_rr_next    = (w_rr_inc >= 4'(N_REQ)) ? 3'd0 : w_rr_inc[2:0];
                w_state_next = StIdle;
            end
            default: begin
                w_grant_next = '0;
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_grant       <= '0;
            r_active_id   <= 3'd0;
            r_rr_ptr      <= 3'd0;
            r_wdog        <= 20'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_active_id   <= w_active_next;
            r_rr_ptr      <= w_rr_next;
            r_wdog        <= w_wdog_next;
            r_timeout_err <= w_timeout_next;
        end
    end

    assign w_uart_start  = |(i_cli_tx_start & r_grant);
    assign o_uart_start  = w_uart_start;
    assign o_uart_data   = (r_grant != '0) ? w_data_pad[{r_active_id, 3'b000} +: 8] : 8'd0;
    assign o_cli_busy    = (r_grant & {N_REQ{i_uart_busy}}) | ~r_grant;
    assign o_grant       = r_grant;
    assign o_active_id   = r_active_id;
    assign o_timeout_err = r_timeout_err;

endmodule
